seq_match_logger: RTL and testbench

//   Downstream consumer of the 1101 Mealy detector's match output (y).

---
 rtl/seq_det_pkg.sv | 8 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/seq_match_logger.sv | 61 ++++++
 tb/tb_seq_match_logger.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared defaults and types for the 1101 detector and its match logger.
package seq_det_pkg;
  localparam int DEF_TS_W  = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 8;

  typedef logic [DEF_TS_W-1:0] ts_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head data is combinational.
module sync_fifo
  import seq_det_pkg::*;
#(
  parameter int WIDTH = DEF_TS_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic                     empty,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Same slot index with differing wrap bits means full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  // Head forced to zero when empty so stale storage never leaks out.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer advance; clear outranks any simultaneous read/write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the head is gated by empty.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/seq_match_logger.sv
// Timestamps detector matches into a FIFO, counts them and flags drops.
module seq_match_logger
  import seq_det_pkg::*;
#(
  parameter int TS_W  = DEF_TS_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   match,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [TS_W-1:0]        rd_ts,
  output logic [CNT_W-1:0]       match_count,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);
  logic [TS_W-1:0] ts;
  logic            full, empty, pop, push;

  // A pop frees the slot the same edge, so full+pop still accepts the write.
  assign rd_valid = ~empty;
  assign pop      = rd_ready & ~empty & ~clear;
  assign push     = match & (~full | pop) & ~clear;

  sync_fifo #(.WIDTH(TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .wr_en   (push),
    .wr_data (ts),
    .full    (full),
    .rd_en   (pop),
    .empty   (empty),
    .rd_data (rd_ts),
    .level   (fifo_level)
  );

  // Free-running timestamp, wraps naturally at 2**TS_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   ts <= '0;
    else if (clear) ts <= '0;
    else            ts <= ts + 1'b1;
  end

  // Saturating match count; dropped events still count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    match_count <= '0;
    else if (clear)                  match_count <= '0;
    else if (match && ~&match_count) match_count <= match_count + 1'b1;
  end

  // Sticky drop flag: event arrived while full with nothing leaving.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     overflow <= 1'b0;
    else if (clear)                   overflow <= 1'b0;
    else if (match && full && !pop)   overflow <= 1'b1;
  end
endmodule

// File: tb/tb_seq_match_logger.sv
// Randomized and directed checks of seq_match_logger against a queue model.
module tb_seq_match_logger;
  localparam int DEPTH = 8;

  logic        clk = 0, reset_n = 0;
  logic        clear = 0, match = 0, rd_ready = 0;
  logic        rd_valid, overflow;
  logic [15:0] rd_ts;
  logic [7:0]  match_count;
  logic [3:0]  fifo_level;

  // small instance for timestamp wrap
  logic        clear2 = 0, match2 = 0, rd_ready2 = 0;
  logic        rd_valid2, overflow2;
  logic [3:0]  rd_ts2;
  logic [7:0]  match_count2;
  logic [2:0]  fifo_level2;

  int n_cmp = 0, n_err = 0;

  // reference model
  int mts, mcnt;
  bit movf;
  int mq[$];

  always #5 clk = ~clk;

  seq_match_logger #(.TS_W(16), .DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .match(match),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ts(rd_ts),
    .match_count(match_count), .fifo_level(fifo_level), .overflow(overflow));

  seq_match_logger #(.TS_W(4), .DEPTH(4), .CNT_W(8)) dut2 (
    .clk(clk), .reset_n(reset_n), .clear(clear2), .match(match2),
    .rd_valid(rd_valid2), .rd_ready(rd_ready2), .rd_ts(rd_ts2),
    .match_count(match_count2), .fifo_level(fifo_level2), .overflow(overflow2));

  task automatic model_reset();
    mq.delete(); mts = 0; mcnt = 0; movf = 0;
  endtask

  // Apply inputs for one edge, advance the model, sample 1ns after the edge.
  task automatic step(input bit m, input bit r, input bit c);
    if (c) model_reset();
    else begin
      if (mq.size() > 0 && r) void'(mq.pop_front());
      if (m) begin
        if (mq.size() < DEPTH) mq.push_back(mts);
        else movf = 1;
        if (mcnt < 255) mcnt++;
      end
      mts = (mts + 1) % 65536;
    end
    match = m; rd_ready = r; clear = c;
    @(posedge clk); #1;
    match = 0; rd_ready = 0; clear = 0;
  endtask

  task automatic do_reset();
    reset_n = 0; match = 1; rd_ready = 0; clear = 0;
    match2 = 0; rd_ready2 = 0; clear2 = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    reset_n = 1; match = 0;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 0; match = 1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", rd_valid); end
    n_cmp++; if (match_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", match_count); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
    n_cmp++; if (rd_ts !== 16'd0) begin n_err++; $display("FAIL reset_ts: got %0d want 0", rd_ts); end
    @(negedge clk);
    reset_n = 1; match = 0;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    while (mts != 5) step(0, 0, 0);
    step(1, 0, 0);
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0b want 1", rd_valid); end
    n_cmp++; if (rd_ts !== 16'd5) begin n_err++; $display("FAIL single_ts: got %0d want 5", rd_ts); end
    n_cmp++; if (fifo_level !== 4'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", fifo_level); end
    n_cmp++; if (match_count !== 8'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", match_count); end
    step(0, 0, 0);
    n_cmp++; if (rd_ts !== 16'd5) begin n_err++; $display("FAIL single_hold: got %0d want 5", rd_ts); end
    step(0, 1, 0);
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid: got %0b want 0", rd_valid); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL single_pop_level: got %0d want 0", fifo_level); end
    // pop request on empty FIFO is a no-op; event + ready on empty just writes
    step(1, 1, 0);
    n_cmp++; if (fifo_level !== 4'd1) begin n_err++; $display("FAIL empty_wr_ready: got %0d want 1", fifo_level); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    while (mts != 10) step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    n_cmp++; if (fifo_level !== 4'd3) begin n_err++; $display("FAIL b2b_level: got %0d want 3", fifo_level); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rd_ts !== 16'(10 + i)) begin n_err++; $display("FAIL b2b_pop%0d: got %0d want %0d", i, rd_ts, 10 + i); end
      step(0, 1, 0);
    end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %0b want 0", rd_valid); end
  endtask

  task automatic test_overflow();
    int first;
    do_reset();
    repeat ($urandom_range(0, 20)) step(0, 0, 0);
    first = mts;
    repeat (10) step(1, 0, 0);
    n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    n_cmp++; if (match_count !== 8'd10) begin n_err++; $display("FAIL ovf_count: got %0d want 10", match_count); end
    n_cmp++; if (rd_ts !== 16'(first)) begin n_err++; $display("FAIL ovf_head: got %0d want %0d", rd_ts, first); end
    // full + event + pop: both happen, nothing lost
    do_reset();
    first = mts;
    repeat (8) step(1, 0, 0);
    step(1, 1, 0);
    n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL fullpop_level: got %0d want 8", fifo_level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf: got %0b want 0", overflow); end
    n_cmp++; if (rd_ts !== 16'(first + 1)) begin n_err++; $display("FAIL fullpop_head: got %0d want %0d", rd_ts, first + 1); end
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    // last popped entry must have been the 9th event (ts = first+8), nothing else left
    n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL fullpop_drain: got %0d want 0", fifo_level); end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (300) step(1, $urandom_range(0, 1), 0);
    n_cmp++; if (match_count !== 8'd255) begin n_err++; $display("FAIL sat_count: got %0d want 255", match_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    // edge k after release samples ts = k-1; edges 17,18 see 16->0 and 1 on a 4-bit counter
    for (int k = 1; k <= 18; k++) begin
      match2 = (k >= 17);
      step(0, 0, 0);
    end
    match2 = 0;
    n_cmp++; if (rd_ts2 !== 4'd0) begin n_err++; $display("FAIL wrap_head: got %0d want 0", rd_ts2); end
    n_cmp++; if (fifo_level2 !== 3'd2) begin n_err++; $display("FAIL wrap_level: got %0d want 2", fifo_level2); end
    rd_ready2 = 1;
    @(posedge clk); #1;
    rd_ready2 = 0;
    n_cmp++; if (rd_ts2 !== 4'd1) begin n_err++; $display("FAIL wrap_next: got %0d want 1", rd_ts2); end
  endtask

  task automatic test_clear();
    do_reset();
    repeat (12) step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    step(0, 0, 0);
    repeat (3) step(0, 1, 0);
    repeat (2) step(0, 1, 0);
    repeat (3) step(1, 0, 0);
    step(1, 1, 1);
    n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL clr_level: got %0d want 0", fifo_level); end
    n_cmp++; if (match_count !== 8'd0) begin n_err++; $display("FAIL clr_count: got %0d want 0", match_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %0b want 0", overflow); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %0b want 0", rd_valid); end
    // ts restarts from 0 after clear
    step(1, 0, 0);
    n_cmp++; if (rd_ts !== 16'd0) begin n_err++; $display("FAIL clr_ts: got %0d want 0", rd_ts); end
    // asynchronous reset mid-stream takes effect without a clock edge
    repeat (3) step(1, 0, 0);
    reset_n = 0;
    #2;
    n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL areset_level: got %0d want 0", fifo_level); end
    n_cmp++; if (match_count !== 8'd0) begin n_err++; $display("FAIL areset_count: got %0d want 0", match_count); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %0b want 0", rd_valid); end
    @(negedge clk);
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_random();
    bit m, r, c;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      m = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 40);
      c = ($urandom_range(0, 199) == 0);
      step(m, r, c);
      n_cmp++; if (rd_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rand_valid cyc %0d: got %0b want %0b", cyc, rd_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        n_cmp++; if (rd_ts !== 16'(mq[0])) begin n_err++; $display("FAIL rand_ts cyc %0d: got %0d want %0d", cyc, rd_ts, mq[0]); end
      end
      n_cmp++; if (fifo_level !== 4'(mq.size())) begin n_err++; $display("FAIL rand_level cyc %0d: got %0d want %0d", cyc, fifo_level, mq.size()); end
      n_cmp++; if (match_count !== 8'(mcnt)) begin n_err++; $display("FAIL rand_count cyc %0d: got %0d want %0d", cyc, match_count, mcnt); end
      n_cmp++; if (overflow !== movf) begin n_err++; $display("FAIL rand_ovf cyc %0d: got %0b want %0b", cyc, overflow, movf); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_saturation();
    test_wrap();
    test_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
